// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// FSM states and the store byte-lane helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  // A lane is enabled when it falls inside [offset, offset + access size).
  function automatic logic lane_enable(input logic [2:0] funct3, input int offset, input int lane);
    int size;
    case (funct3[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      default: size = 4;
    endcase
    return (lane >= offset) && (lane < offset + size);
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the EX/MEM stage and the data-memory LSU.
interface dmem_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_fault;
  logic              busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, busy
  );

endinterface

// File: rtl/dmem_load_align.sv
// Load lane selection and sign/zero extension applied to the registered read word.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  word,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  result
);

  localparam int WORD_MSB = (XLEN > 32) ? 31 : XLEN - 1;

  logic [XLEN-1:0] shifted;
  int              msb;
  logic            sgn;

  // Bring the addressed lane down to bit 0, then extend from the access MSB.
  always_comb begin
    result  = '0;
    shifted = word >> {offset, 3'b000};
    msb     = WORD_MSB;
    sgn     = 1'b1;
    case (funct3)
      F3_B:    msb = 7;
      F3_H:    msb = 15;
      F3_BU: begin
        msb = 7;
        sgn = 1'b0;
      end
      F3_HU: begin
        msb = 15;
        sgn = 1'b0;
      end
      default: msb = WORD_MSB;
    endcase
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (i <= msb) ? shifted[i] : (sgn & shifted[msb]);
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-lane data RAM with RV32I load/store front-end, fault detection and a
// post-reset clear sweep; loads respond exactly one cycle after accept.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * NB);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  clr_cnt;
  logic [XLEN-1:0]   mem [DEPTH];

  logic              accept;
  logic              illegal;
  logic              misalign;
  logic              out_of_range;
  logic              fault;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [NB-1:0]     wr_be;
  logic [XLEN-1:0]   wr_data;

  logic              resp_q;
  logic              fault_q;
  logic              load_q;
  logic [2:0]        funct3_q;
  logic [OFF_W-1:0]  off_q;
  logic [XLEN-1:0]   rd_word;
  logic [XLEN-1:0]   aligned;

  assign req_idx = bus.req_addr[OFF_W +: IDX_W];
  assign req_off = bus.req_addr[OFF_W-1:0];
  assign accept  = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        bus.busy = 1'b1;
        if (clr_cnt == IDX_W'(DEPTH - 1)) state_next = ST_RUN;
      end
      ST_RUN:  bus.req_ready = 1'b1;
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  always_comb begin
    illegal = bus.req_we ? (bus.req_funct3 > F3_W)
                         : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));
    misalign = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = (bus.req_addr[1:0] != 2'b00) || (NB < 4);
      default: misalign = 1'b0;
    endcase
    out_of_range = {1'b0, bus.req_addr} >= MEM_BYTES;
    fault        = illegal | misalign | out_of_range;
  end

  // Single write port shared by the clear sweep and non-faulting stores.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = req_idx;
    wr_be   = '0;
    wr_data = '0;
    if (state == ST_CLEAR) begin
      wr_en  = 1'b1;
      wr_idx = clr_cnt;
      wr_be  = '1;
    end else if (accept && bus.req_we && !fault) begin
      wr_en = 1'b1;
      for (int i = 0; i < NB; i++) begin
        wr_be[i] = lane_enable(bus.req_funct3, int'(req_off), i);
        case (bus.req_funct3[1:0])
          2'b00:   wr_data[8*i +: 8] = bus.req_wdata[7:0];
          2'b01:   wr_data[8*i +: 8] = bus.req_wdata[8*(i%2) +: 8];
          default: wr_data[8*i +: 8] = bus.req_wdata[8*(i%4) +: 8];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !bus.req_we) rd_word <= mem[req_idx];
  end

  // Response bookkeeping; reset drops any response in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q   <= 1'b0;
      fault_q  <= 1'b0;
      load_q   <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
    end else begin
      resp_q   <= accept;
      fault_q  <= accept & fault;
      load_q   <= accept & !bus.req_we & !fault;
      funct3_q <= bus.req_funct3;
      off_q    <= req_off;
    end
  end

  dmem_load_align #(.XLEN(XLEN)) u_align (
    .word   (rd_word),
    .offset (off_q),
    .funct3 (funct3_q),
    .result (aligned)
  );

  assign bus.resp_valid = resp_q;
  assign bus.resp_fault = fault_q;
  assign bus.resp_rdata = load_q ? aligned : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Table-driven scoreboard bench for dmem_lsu: clear sweep timing, load/store
// sizes, faults, store-to-load forwarding and reset during a pending response.
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   tests_run    = 0;
  int   tests_failed = 0;

  exp_t  sb[$];
  string name_q[$];
  vec_t  vecs[$];
  exp_t  mon_exp;
  string mon_name;

  always #5 clk = ~clk;

  dmem_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  dmem_lsu #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Responses are due exactly one cycle after the accept edge that pushed them.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_exp  = sb.pop_front();
      mon_name = name_q.pop_front();
      check_output(mon_name, {30'b0, bus.resp_valid, bus.resp_fault, bus.resp_rdata},
                   {30'b0, 1'b1, mon_exp.fault, mon_exp.rdata});
    end else begin
      check_output("idle_resp", {30'b0, bus.resp_valid, bus.resp_fault, bus.resp_rdata}, 64'd0);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input string name, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_fault);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    sb.push_back('{rdata: exp_rdata, fault: exp_fault});
    name_q.push_back(name);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
  endtask

  task automatic wait_clear();
    int cnt;
    logic ready_low;
    cnt       = 0;
    ready_low = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.busy) begin
        cnt++;
        if (bus.req_ready) ready_low = 1'b0;
      end else begin
        break;
      end
    end
    check_output("clear_cycles", 64'(cnt), 64'd1024);
    check_output("ready_low_during_clear", {63'b0, ready_low}, 64'd1);
    check_output("ready_after_clear", {63'b0, bus.req_ready}, 64'd1);
    check_output("busy_after_clear", {63'b0, bus.busy}, 64'd0);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    check_output(name, 64'(sb.size()), 64'd0);
  endtask

  function automatic void add_vec(input string name, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rdata, input logic exp_fault);
    vecs.push_back('{name: name, we: we, f3: f3, addr: addr, wdata: wdata,
                     exp_rdata: exp_rdata, exp_fault: exp_fault});
  endfunction

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // Freshly cleared memory reads as zero.
    add_vec("lw_0x000",      0, F3_W,   32'h000, 32'h0, 32'h0, 0);
    add_vec("lw_0x3fc",      0, F3_W,   32'h3FC, 32'h0, 32'h0, 0);
    add_vec("lw_0x200",      0, F3_W,   32'h200, 32'h0, 32'h0, 0);
    add_vec("lw_0xffc",      0, F3_W,   32'hFFC, 32'h0, 32'h0, 0);
    // Sub-word loads over a known word.
    add_vec("sw_deadbeef",   1, F3_W,   32'h010, 32'hDEADBEEF, 32'h0, 0);
    add_vec("lb_0x10",       0, F3_B,   32'h010, 32'h0, 32'hFFFFFFEF, 0);
    add_vec("lb_0x11",       0, F3_B,   32'h011, 32'h0, 32'hFFFFFFBE, 0);
    add_vec("lb_0x12",       0, F3_B,   32'h012, 32'h0, 32'hFFFFFFAD, 0);
    add_vec("lb_0x13",       0, F3_B,   32'h013, 32'h0, 32'hFFFFFFDE, 0);
    add_vec("lbu_0x13",      0, F3_BU,  32'h013, 32'h0, 32'h000000DE, 0);
    add_vec("lhu_0x12",      0, F3_HU,  32'h012, 32'h0, 32'h0000DEAD, 0);
    add_vec("lh_0x12",       0, F3_H,   32'h012, 32'h0, 32'hFFFFDEAD, 0);
    add_vec("lh_0x10",       0, F3_H,   32'h010, 32'h0, 32'hFFFFBEEF, 0);
    add_vec("lhu_0x10",      0, F3_HU,  32'h010, 32'h0, 32'h0000BEEF, 0);
    // Back-to-back partial stores merge into one word.
    add_vec("sw_0_0x20",     1, F3_W,   32'h020, 32'h00000000, 32'h0, 0);
    add_vec("sb_7f_0x22",    1, F3_B,   32'h022, 32'hAAAAAA7F, 32'h0, 0);
    add_vec("sh_1234_0x20",  1, F3_H,   32'h020, 32'h55551234, 32'h0, 0);
    add_vec("lw_0x20",       0, F3_W,   32'h020, 32'h0, 32'h007F1234, 0);
    // Faults leave memory untouched.
    add_vec("lw_0x22_mis",   0, F3_W,   32'h022, 32'h0, 32'h0, 1);
    add_vec("sh_0x21_mis",   1, F3_H,   32'h021, 32'h0000FFFF, 32'h0, 1);
    add_vec("lh_0x21_mis",   0, F3_H,   32'h021, 32'h0, 32'h0, 1);
    add_vec("lw_0x1000_oor", 0, F3_W,   32'h1000, 32'h0, 32'h0, 1);
    add_vec("lb_max_oor",    0, F3_B,   32'hFFFFFFFF, 32'h0, 32'h0, 1);
    add_vec("ld_f3_011",     0, 3'b011, 32'h020, 32'h0, 32'h0, 1);
    add_vec("ld_f3_110",     0, 3'b110, 32'h020, 32'h0, 32'h0, 1);
    add_vec("sw_0x1000_oor", 1, F3_W,   32'h1000, 32'hFFFFFFFF, 32'h0, 1);
    add_vec("sw_0x22_mis",   1, F3_W,   32'h022, 32'hFFFFFFFF, 32'h0, 1);
    add_vec("st_f3_100",     1, 3'b100, 32'h020, 32'hFFFFFFFF, 32'h0, 1);
    add_vec("lw_0x20_kept",  0, F3_W,   32'h020, 32'h0, 32'h007F1234, 0);
    // Top of the array.
    add_vec("lw_0xffd_mis",  0, F3_W,   32'hFFD, 32'h0, 32'h0, 1);
    add_vec("sb_80_0xfff",   1, F3_B,   32'hFFF, 32'h00000080, 32'h0, 0);
    add_vec("lb_0xfff",      0, F3_B,   32'hFFF, 32'h0, 32'hFFFFFF80, 0);
    add_vec("lbu_0xfff",     0, F3_BU,  32'hFFF, 32'h0, 32'h00000080, 0);
    add_vec("lh_0xffe",      0, F3_H,   32'hFFE, 32'h0, 32'hFFFF8000, 0);
    add_vec("lw_0xffc_top",  0, F3_W,   32'hFFC, 32'h0, 32'h80000000, 0);
    // Store immediately followed by a load of the same word.
    add_vec("sw_cafef00d",   1, F3_W,   32'h040, 32'hCAFEF00D, 32'h0, 0);
    add_vec("lw_0x40",       0, F3_W,   32'h040, 32'h0, 32'hCAFEF00D, 0);

    repeat (3) @(negedge clk);
    check_output("reset_ready", {63'b0, bus.req_ready}, 64'd0);
    check_output("reset_busy", {63'b0, bus.busy}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_clear();

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr,
                     vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_fault);
    end
    wait_drain("drain_table");

    // Reset lands while a load response is on the outputs.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_output("pending_before_reset", {31'b0, bus.resp_valid, bus.resp_rdata}, {31'b0, 1'b1, 32'hDEADBEEF});
    rst = 1'b1;
    #1;
    check_output("resp_dropped_on_reset", {62'b0, bus.resp_valid, bus.resp_fault}, 64'd0);
    check_output("busy_on_reset", {63'b0, bus.busy}, 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_clear();
    apply_stimulus("lw_0x10_after_reclear", 0, F3_W, 32'h010, 32'h0, 32'h0, 0);
    wait_drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised successor to the single-port data memory for the RISC-V core.
- Word-organised, byte-lane-enabled data RAM with a full load/store unit front-end: RV32I sizes (B/H/W, signed/unsigned), alignment and range fault detection, and a valid/ready request interface.
- Read is registered with a fixed 1-cycle response latency.
- After reset, a hardware clear sweep zeroes the whole array. Sits between the EX/MEM pipeline stage and writeback.

Parameters:
- XLEN, 32, data width in bits; multiple of 8, at least 16.
- DEPTH, 1024, number of XLEN-bit words; power of two.
- ADDR_W, 32, byte-address width of req_addr.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I load/store funct3.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  XLEN  store data; low bits used for SB/SH.
- resp_valid  output  1  response present, exactly 1 cycle after accept.
- resp_rdata  output  XLEN  load result, already extended; 0 for stores and faults.
- resp_fault  output  1  request was misaligned, out of range, or illegal funct3.
- busy  output  1  clear sweep in progress.

Behaviour:
- Reset (async, while asserted): req_ready=0, resp_valid=0, resp_rdata=0, resp_fault=0, busy=1, clear counter=0, state=CLEAR.
- Reset mid-operation: any in-flight response is dropped (resp_valid forced to 0) and the clear sweep restarts from word 0.
- FSM states are CLEAR and RUN.
- CLEAR:
  - Writes 0 to word clr_cnt each cycle and increments clr_cnt.
  - busy=1 and req_ready=0 throughout.
  - After word DEPTH-1 is written, go to RUN. The sweep takes exactly DEPTH cycles after reset release.
- RUN:
  - req_ready=1 and busy=0 permanently.
  - A request is accepted on an edge where req_valid and req_ready are both 1.
- Word index = req_addr[log2(DEPTH)+1:2]; byte offset = req_addr[1:0].
- Fault conditions (checked at accept):
  - req_addr >= DEPTH*XLEN/8.
  - Halfword access with addr[0] != 0.
  - Word access with addr[1:0] != 0.
  - Load with funct3 in {011, 110, 111}.
  - Store with funct3 not in {000, 001, 010}.
- A faulting request does not modify memory. Its response is resp_fault=1, resp_rdata=0.
- Store encodings: funct3 000=SB, 001=SH, 010=SW.
  - Byte enables are derived from size and offset; the data is replicated into the addressed lanes.
  - The array is written at the accept edge.
  - The response is resp_fault=0, resp_rdata=0.
- Load encodings: 000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU.
  - The array word is read at the accept edge into a register.
  - The lane is selected by offset. Signed loads sign-extend to XLEN; unsigned loads zero-extend.
  - resp_rdata is valid with resp_valid on the next cycle.
- Throughput: one request per cycle, fully pipelined, with no response back-pressure (the consumer is always ready).
- Consecutive accesses:
  - A load accepted the cycle after a store to the same word returns the stored data; the write has completed at the earlier edge.
  - Same-edge read/write collision cannot occur, because there is only one request per edge.
- resp_valid=0 on any cycle with no accept in the previous cycle. resp_rdata and resp_fault then return to 0.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding: ST_CLEAR, ST_RUN.
  - Helper function for byte-enable generation from size and offset.
- One sub-module: dmem_load_align. It is combinational: raw word + offset + funct3 in, extended result out. It is instantiated on the registered read path.

Test Plan:
- Reset, then count cycles → busy=1 and req_ready=0 for exactly 1024 cycles; then req_ready=1. LW at 0x000, 0x3FC, 0x200 → 0x00000000 each.
- SW 0xDEADBEEF @0x10, then LB @0x10,0x11,0x12,0x13 → 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE. LBU @0x13 → 0x000000DE. LHU @0x12 → 0x0000DEAD. LH @0x12 → 0xFFFFDEAD.
- SW 0 @0x20, SB 0x7F @0x22, SH 0x1234 @0x20 in back-to-back cycles, then LW @0x20 next cycle → 0x007F1234; resp_valid high every cycle of the burst.
- Faults:
  - LW @0x22, SH @0x21, LW @0x1000, funct3=011 load → each gives resp_fault=1, resp_rdata=0.
  - A faulting SW 0xFFFFFFFF @0x1000 or @0x22 → following LW @0x20 shows memory unchanged.
- Store then immediate load, same word: SW 0xCAFEF00D @0x40 accepted at cycle N, LW @0x40 at N+1 → 0xCAFEF00D at N+2.
- Assert rst while a load response is pending → resp_valid=0 immediately. After release, the clear sweep restarts (busy for 1024 cycles) and LW @0x10 → 0.
